// File: rtl/change_queue_pkg.sv
// change_queue_pkg
// Package shared by change_queue and change_queue_mem.
// Pulls in the shared geometry/pointer definitions and names the four
// operations the queue can perform in a cycle.
package change_queue_pkg;

`include "change_queue_defs.vh"

    // Operation decoded each cycle from {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } queue_op_e;

endpackage

// File: rtl/change_queue_defs.vh
// change_queue_defs.vh
// Shared definitions for the change_queue block: default geometry and the
// pointer-width helper. Meant to be included inside change_queue_pkg so the
// constants and the function are reachable through a package import.
`ifndef CHANGE_QUEUE_DEFS_VH
`define CHANGE_QUEUE_DEFS_VH

    // Default bit width of each captured value.
    localparam int CQ_DEFAULT_WIDTH = 4;

    // Default number of queue entries (power of two, 2..16).
    localparam int CQ_DEFAULT_DEPTH = 4;

    // Width of the read/write pointers. A depth of 1 would give a zero-width
    // pointer, so clamp to one bit.
    function automatic int cqPtrWidth(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

`endif

// File: rtl/change_queue_mem.sv
// change_queue_mem
// DEPTH x WIDTH register array for the change queue.
// Ports:
//   iClk     - clock, writes happen on the rising edge
//   iWrEn    - write enable
//   iWrAddr  - write address
//   iWrData  - write data
//   iRdAddr  - read address (asynchronous read)
//   oRdData  - contents of entry iRdAddr
// Contents are not reset; the owner tracks which entries are live.
module change_queue_mem
    import change_queue_pkg::*;
#(
    parameter int WIDTH = CQ_DEFAULT_WIDTH,
    parameter int DEPTH = CQ_DEFAULT_DEPTH,
    localparam int PW   = cqPtrWidth(DEPTH)
) (
    input  logic             iClk,
    input  logic             iWrEn,
    input  logic [PW-1:0]    iWrAddr,
    input  logic [WIDTH-1:0] iWrData,
    input  logic [PW-1:0]    iRdAddr,
    output logic [WIDTH-1:0] oRdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWrEn) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = mem[iRdAddr];

endmodule

// File: rtl/change_queue.sv
// change_queue
// Small circular queue that buffers change events for a downstream consumer.
//
// Handshake: a push happens in every cycle with iChange=1 (no back-pressure
// towards the producer). The head entry is offered while oValid=1 and is
// consumed in a cycle where oValid=1 and iAck=1; iAck while oValid=0 is
// ignored. oData/oValid are registered, so a value pushed into an empty queue
// appears one cycle later.
//
// Ports:
//   iClk      - clock
//   iReset    - synchronous, active-high reset
//   iChange   - change strobe (push)
//   iData     - value captured with iChange
//   oData     - head-of-queue value, meaningful while oValid=1
//   oValid    - queue non-empty
//   iAck      - consumer accepts head entry
//   oCount    - number of stored entries, 0..DEPTH
//   oOverflow - sticky: an event arrived while full with no pop
//
// Build option:
//   CHANGE_QUEUE_KEEP_LATEST_EN - when defined, a push into a full queue
//   (without a pop) overwrites the newest entry instead of dropping iData.
module change_queue
    import change_queue_pkg::*;
#(
    parameter int WIDTH = CQ_DEFAULT_WIDTH,
    parameter int DEPTH = CQ_DEFAULT_DEPTH,
    localparam int PW   = cqPtrWidth(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iChange,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    input  logic             iAck,
    output logic [CW-1:0]    oCount,
    output logic             oOverflow
);

    logic [PW-1:0]    wrPtr, wrPtrNext;
    logic [PW-1:0]    rdPtr, rdPtrNext;
    logic [CW-1:0]    count, countNext;
    logic             validQ, validNext;
    logic [WIDTH-1:0] dataQ, dataNext;
    logic             ovfQ, ovfNext;

    logic             memWe;
    logic [PW-1:0]    memWa;
    logic [WIDTH-1:0] memRd;

    logic             full;
    logic             push;
    logic             pop;
    queue_op_e        op;

    assign full = (count == CW'(DEPTH));
    assign push = iChange;
    assign pop  = validQ & iAck;
    assign op   = queue_op_e'({push, pop});

    change_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uMem (
        .iClk    (iClk),
        .iWrEn   (memWe),
        .iWrAddr (memWa),
        .iWrData (iData),
        .iRdAddr (rdPtrNext),
        .oRdData (memRd)
    );

    always_comb begin
        wrPtrNext = wrPtr;
        rdPtrNext = rdPtr;
        countNext = count;
        ovfNext   = ovfQ;
        memWe     = 1'b0;
        memWa     = wrPtr;

        case (op)
            OP_PUSH: begin
                if (!full) begin
                    memWe     = 1'b1;
                    wrPtrNext = wrPtr + PW'(1);
                    countNext = count + CW'(1);
                end else begin
                    ovfNext = 1'b1;
`ifdef CHANGE_QUEUE_KEEP_LATEST_EN
                    // Replace the newest entry; pointers and count stay put.
                    memWe = 1'b1;
                    memWa = wrPtr - PW'(1);
`endif
                end
            end
            OP_POP: begin
                rdPtrNext = rdPtr + PW'(1);
                countNext = count - CW'(1);
            end
            OP_BOTH: begin
                // Also legal when full: the slot being freed by the pop is
                // the one the write pointer targets.
                memWe     = 1'b1;
                wrPtrNext = wrPtr + PW'(1);
                rdPtrNext = rdPtr + PW'(1);
            end
            default: begin
            end
        endcase

        // Reset cycle ignores the strobes entirely.
        if (iReset) begin
            memWe = 1'b0;
        end

        validNext = (countNext != '0);

        // Registered head: the memory read happens before this edge's write
        // lands, so forward iData when the new head slot is being written now.
        if (!validNext) begin
            dataNext = dataQ;
        end else if (memWe && (memWa == rdPtrNext)) begin
            dataNext = iData;
        end else begin
            dataNext = memRd;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            validQ <= 1'b0;
            dataQ  <= '0;
            ovfQ   <= 1'b0;
        end else begin
            wrPtr  <= wrPtrNext;
            rdPtr  <= rdPtrNext;
            count  <= countNext;
            validQ <= validNext;
            dataQ  <= dataNext;
            ovfQ   <= ovfNext;
        end
    end

    assign oData     = dataQ;
    assign oValid    = validQ;
    assign oCount    = count;
    assign oOverflow = ovfQ;

endmodule

// File: tb/tb_change_queue.sv
// tb_change_queue
// Directed bench for change_queue at default geometry (WIDTH=4, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge has settled.
module tb_change_queue;

    logic       iClk;
    logic       iReset;
    logic       iChange;
    logic [3:0] iData;
    logic [3:0] oData;
    logic       oValid;
    logic       iAck;
    logic [2:0] oCount;
    logic       oOverflow;

    int checks   = 0;
    int failures = 0;

    change_queue dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iChange   (iChange),
        .iData     (iData),
        .oData     (oData),
        .oValid    (oValid),
        .iAck      (iAck),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        iChange = 1'b1;
        iData   = v;
        step();
        iChange = 1'b0;
    endtask

    task automatic ackOne(input string tag, input logic [3:0] exp);
        check({tag, "_valid"}, {7'd0, oValid}, 8'd1);
        check({tag, "_data"}, {4'd0, oData}, {4'd0, exp});
        iAck = 1'b1;
        step();
        iAck = 1'b0;
    endtask

    task automatic doReset();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
    endtask

    initial begin
        iReset  = 1'b1;
        iChange = 1'b0;
        iData   = 4'h0;
        iAck    = 1'b0;
        step();
        step();
        iReset = 1'b0;

        // Reset state
        check("rst_valid", {7'd0, oValid}, 8'd0);
        check("rst_count", {5'd0, oCount}, 8'd0);
        check("rst_ovf",   {7'd0, oOverflow}, 8'd0);
        check("rst_data",  {4'd0, oData}, 8'd0);

        // Single push/pop with one-cycle latency
        push(4'hA);
        check("single_valid", {7'd0, oValid}, 8'd1);
        check("single_data",  {4'd0, oData}, 8'h0A);
        check("single_count", {5'd0, oCount}, 8'd1);
        iAck = 1'b1;
        step();
        iAck = 1'b0;
        check("single_empty_valid", {7'd0, oValid}, 8'd0);
        check("single_empty_count", {5'd0, oCount}, 8'd0);

        // Ack while empty is ignored; pointers stay aligned
        iAck = 1'b1;
        step();
        iAck = 1'b0;
        check("idle_ack_count", {5'd0, oCount}, 8'd0);
        check("idle_ack_valid", {7'd0, oValid}, 8'd0);
        push(4'hB);
        check("after_idle_ack_data",  {4'd0, oData}, 8'h0B);
        check("after_idle_ack_count", {5'd0, oCount}, 8'd1);
        ackOne("drain_b", 4'hB);
        check("drain_b_empty", {7'd0, oValid}, 8'd0);

        // Fill to capacity, drain in order
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        check("fill_count", {5'd0, oCount}, 8'd4);
        check("fill_data",  {4'd0, oData}, 8'h01);
        check("fill_ovf",   {7'd0, oOverflow}, 8'd0);
        ackOne("fill_d1", 4'h1);
        ackOne("fill_d2", 4'h2);
        ackOne("fill_d3", 4'h3);
        ackOne("fill_d4", 4'h4);
        check("fill_empty_valid", {7'd0, oValid}, 8'd0);
        check("fill_empty_count", {5'd0, oCount}, 8'd0);

        // Push while full: overflow and full-case data handling
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        push(4'h9);
        check("ovf_flag",  {7'd0, oOverflow}, 8'd1);
        check("ovf_count", {5'd0, oCount}, 8'd4);
        check("ovf_head",  {4'd0, oData}, 8'h01);
        ackOne("ovf_d1", 4'h1);
        ackOne("ovf_d2", 4'h2);
        ackOne("ovf_d3", 4'h3);
`ifdef CHANGE_QUEUE_KEEP_LATEST_EN
        ackOne("ovf_d4", 4'h9);
`else
        ackOne("ovf_d4", 4'h4);
`endif
        check("ovf_empty_valid", {7'd0, oValid}, 8'd0);
        check("ovf_sticky",      {7'd0, oOverflow}, 8'd1);
        doReset();
        check("ovf_cleared", {7'd0, oOverflow}, 8'd0);

        // Simultaneous push and pop while full
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        iChange = 1'b1;
        iData   = 4'h7;
        iAck    = 1'b1;
        step();
        iChange = 1'b0;
        iAck    = 1'b0;
        check("both_count", {5'd0, oCount}, 8'd4);
        check("both_ovf",   {7'd0, oOverflow}, 8'd0);
        check("both_data",  {4'd0, oData}, 8'h02);
        ackOne("both_d2", 4'h2);
        ackOne("both_d3", 4'h3);
        ackOne("both_d4", 4'h4);
        ackOne("both_d7", 4'h7);
        check("both_empty_valid", {7'd0, oValid}, 8'd0);

        // Wrap: overlapped push/pop pairs carrying 0..9
        push(4'h0);
        for (int i = 1; i < 10; i++) begin
            check("wrap_count", {5'd0, oCount}, 8'd1);
            check("wrap_data",  {4'd0, oData}, 8'(i - 1));
            iChange = 1'b1;
            iData   = 4'(i);
            iAck    = 1'b1;
            step();
            iChange = 1'b0;
            iAck    = 1'b0;
        end
        check("wrap_last_count", {5'd0, oCount}, 8'd1);
        ackOne("wrap_d9", 4'h9);
        check("wrap_empty_valid", {7'd0, oValid}, 8'd0);
        check("wrap_empty_count", {5'd0, oCount}, 8'd0);
        check("wrap_ovf",         {7'd0, oOverflow}, 8'd0);

        // Reset mid-operation with a push in the reset cycle
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        push(4'h5);
        iAck = 1'b1;
        step();
        iAck = 1'b0;
        check("pre_rst_count", {5'd0, oCount}, 8'd3);
        check("pre_rst_ovf",   {7'd0, oOverflow}, 8'd1);
        iReset  = 1'b1;
        iChange = 1'b1;
        iData   = 4'hE;
        step();
        iReset  = 1'b0;
        iChange = 1'b0;
        check("mid_rst_valid", {7'd0, oValid}, 8'd0);
        check("mid_rst_count", {5'd0, oCount}, 8'd0);
        check("mid_rst_ovf",   {7'd0, oOverflow}, 8'd0);
        step();
        check("mid_rst_no_capture", {7'd0, oValid}, 8'd0);
        check("mid_rst_count2",     {5'd0, oCount}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
